seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 233 +++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Converts an unsigned binary value to DIGITS BCD digits with a sequential
// shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto
// one shared, active-high 7-segment bus using a one-hot digit enable.
//
// Parameters
//   DIGITS    number of display digits (1..8); digit 0 is least significant
//   BIN_W     width of bin_in (1..27)
//   SCAN_DIV  clk cycles each digit stays enabled (>= 1)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active-high
//   bin_in  in   value to display, captured when load & ready
//   load    in   conversion request; ignored while ready is low
//   ready   out  idle and able to accept load
//   seg     out  segments {a,b,c,d,e,f,g}, a = bit 6, registered
//   dig_en  out  one-hot digit enable, registered
//   ovf     out  displayed value does not fit in DIGITS digits (dashes shown)
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          non-zero digit are blanked (digit 0 never is).
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              load,
  output logic              ready,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en,
  output logic              ovf
);

  // One spare bit above the top nibble catches values >= 10^DIGITS.
  localparam int unsigned BCD_W = 4 * DIGITS + 1;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE   = DIGITS'(1);
  localparam logic [6:0]        SEG_DASH  = 7'h01;
  localparam logic [6:0]        SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic do_accept;
  logic do_shift;
  logic do_commit;

  logic [BIN_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  iter_q;
  logic              sticky_q;

  logic [DIGITS-1:0][3:0] disp_q;
  logic                   ovf_q;
  logic                   digit_blank;

  logic [PRE_W-1:0]  presc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [6:0]        seg_d;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] dig_en_q;

  // ---------------------------------------------------------------------------
  // Conversion FSM: state register, next-state logic, output decode.
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge value of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output is given a default before the case, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (load)                 state_d = S_CONV;
      S_CONV:   if (iter_q == LAST_ITER)  state_d = S_COMMIT;
      S_COMMIT:                           state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    do_accept = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready     = 1'b1;
        do_accept = load;
      end
      S_CONV:   do_shift  = 1'b1;
      S_COMMIT: do_commit = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double-dabble engine: add 3 to each nibble >= 5, then shift in the MSB.
  // Any bit pushed out of the spare top bit marks the value as overflowing.
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: the conversion datapath has no reset; it is fully reinitialised on
  // every accept and never observed outside CONV/COMMIT. Only state and the
  // visible display buffer need a reset value.
  always_ff @(posedge clk) begin
    if (do_accept) begin
      bin_q    <= bin_in;
      bcd_q    <= '0;
      iter_q   <= '0;
      sticky_q <= 1'b0;
    end else if (do_shift) begin
      bcd_q    <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q    <= bin_q << 1;
      iter_q   <= iter_q + 1'b1;
      sticky_q <= sticky_q | bcd_adj[BCD_W-1];
    end
  end

  // Display buffer: loaded in one clock at COMMIT, so no partial value is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (do_commit) begin
      disp_q <= bcd_q[4*DIGITS-1:0];
      ovf_q  <= sticky_q | bcd_q[BCD_W-1];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              upper_zero;

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (bcd_q[4*i +: 4] == 4'd0);
      blank_d[i] = upper_zero;
    end
  end

  // Reset matches the mask of the all-zero buffer (a single "0").
  always_ff @(posedge clk) begin
    if (rst)            blank_q <= ~DIG_ONE;
    else if (do_commit) blank_q <= blank_d;
  end

  assign digit_blank = blank_q[idx_q];
`else
  assign digit_blank = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scan: prescaler paces the digit index; seg/dig_en are registered from it.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    if (ovf_q)            seg_d = SEG_DASH;
    else if (digit_blank) seg_d = SEG_BLANK;
    else                  seg_d = seg_of(disp_q[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      dig_en_q <= '0;
    end else begin
      seg_q    <= seg_d;
      dig_en_q <= DIG_ONE << idx_q;
      if (presc_q == PRE_LAST) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Scoreboard bench for seg7_scan_driver. Each accepted load pushes the
// expected display, which is computed arithmetically from the value. A monitor
// pops the entry on every completed conversion (ready rising) and compares ovf
// and one full scan of seg/dig_en. A separate process measures the length of
// every ready-low window.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 3;
  localparam int SCAN_CYC = DIGITS * SCAN_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic [BIN_W-1:0]  bin_in;
  logic              load;
  logic              ready;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_en;
  logic              ovf;

  seg7_scan_driver #(
    .DIGITS  (DIGITS),
    .BIN_W   (BIN_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bin_in(bin_in),
    .load  (load),
    .ready (ready),
    .seg   (seg),
    .dig_en(dig_en),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DIGITS-1:0][6:0] seg;
    logic                   ovf;
    int unsigned            value;
  } exp_t;

  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  exp_t sb_q[$];
  logic mon_busy = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
  endtask

  // Reference: decimal digits from division, dashes when out of range.
  function automatic exp_t model(input int unsigned v);
    exp_t        e;
    int unsigned p;
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    e.value = v;
    e.ovf   = (v >= lim);
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (e.ovf) e.seg[i] = 7'h01;
`ifdef LEADING_ZERO_BLANK_EN
      else if (i > 0 && v < p) e.seg[i] = 7'h00;
`endif
      else e.seg[i] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: a completed conversion is signalled by ready rising.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic              prev_ready;
    exp_t              e;
    logic [DIGITS-1:0] seen;
    int                idx;
    prev_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready && !prev_ready) begin
        mon_busy = 1'b1;
        check("sb_depth_at_commit", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check($sformatf("ovf_v%0d", e.value), ovf, e.ovf);
          seen = '0;
          for (int k = 0; k < SCAN_CYC; k++) begin
            @(posedge clk); #1;
            check("dig_en_onehot", $onehot(dig_en), 1);
            idx = 0;
            for (int j = 0; j < DIGITS; j++) if (dig_en[j]) idx = j;
            if ($onehot(dig_en)) begin
              seen |= dig_en;
              check($sformatf("seg_d%0d_v%0d", idx, e.value), seg, e.seg[idx]);
            end
          end
          check($sformatf("all_digits_v%0d", e.value), seen, {DIGITS{1'b1}});
        end
        mon_busy = 1'b0;
      end
      prev_ready = ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Ready-window timer: ready must stay low exactly BIN_W+1 cycles per accept.
  // ---------------------------------------------------------------------------
  initial begin : ready_timer
    int cnt;
    bit aborted;
    @(negedge clk); #1;
    forever begin
      if (!rst && ready && load) begin
        cnt     = 0;
        aborted = 1'b0;
        forever begin
          @(negedge clk); #1;
          if (rst) begin aborted = 1'b1; break; end
          if (ready || cnt > 100) break;
          cnt++;
        end
        if (!aborted) check("ready_low_cycles", cnt, BIN_W + 1);
      end else begin
        @(negedge clk); #1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input int unsigned v, input bit hold, input bit expect_commit);
    int w;
    w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_load", ready, 1);
    bin_in = BIN_W'(v);
    load   = 1'b1;
    if (expect_commit) sb_q.push_back(model(v));
    @(negedge clk);
    if (!hold) load = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || mon_busy || !ready) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_in_time", (w < 500), 1);
  endtask

  initial begin : stimulus
    exp_t        e0;
    int unsigned v;
    bit          hold;
    rst    = 1'b1;
    load   = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h00);
    check("rst_dig_en", dig_en, 0);
    check("rst_ready", ready, 1);
    check("rst_ovf", ovf, 0);

    // Scan from reset: first cycle blank, then each digit for SCAN_DIV cycles.
    rst = 1'b0;
    check("dig_en_first_cycle", dig_en, 0);
    e0 = model(0);
    for (int k = 0; k < SCAN_CYC + 1; k++) begin
      @(negedge clk);
      check("scan_dig_en", dig_en, 1 << ((k / SCAN_DIV) % DIGITS));
      check("scan_seg", seg, e0.seg[(k / SCAN_DIV) % DIGITS]);
    end

    issue(1234, 1'b0, 1'b1);
    issue(9999, 1'b0, 1'b1);
    issue(10000, 1'b0, 1'b1);
    issue(7, 1'b0, 1'b1);

    // A load pulsed mid-conversion must be ignored.
    issue(5678, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bin_in = BIN_W'(1111);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    drain();

    // Reset mid-conversion: buffer returns to zeros, 4321 is never committed.
    issue(4321, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    sb_q.push_back(model(0));
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_ovf", ovf, 0);
    rst = 1'b0;
    drain();

    issue(42, 1'b0, 1'b1);
    issue(0, 1'b0, 1'b1);
    issue(16383, 1'b0, 1'b1);
    issue(10, 1'b0, 1'b1);

    // Load held high: back-to-back conversions.
    issue(1, 1'b1, 1'b1);
    issue(2, 1'b1, 1'b1);
    issue(3, 1'b0, 1'b1);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, (1 << BIN_W) - 1);
      else                           v = $urandom_range(0, 9999);
      hold = (n != 15) && ($urandom_range(0, 1) == 1);
      issue(v, hold, 1'b1);
    end
    load = 1'b0;

    drain();
    check("sb_empty_at_end", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
